therm_n1_memory_arbiter: RTL and testbench
==========================================

Name: therm_n1_memory_arbiter

Overview:
- Sequences the single-ported therm_simple_memory between the two CPU requesters: instruction fetch (port 0) and load/store (port 1).
- Grants one requester at a time and drives chip_enable, write_enable, address and data_store.
- Counts the fixed memory latency, then returns load data or a write completion to the granted port.
- Sits between the therm_n1 fetch/decode stages and the memory interface; it replaces their direct, conflicting drives of that interface.

Parameters:
- ADDR_WIDTH, 64, width of requester and memory addresses.
- DATA_WIDTH, 64, width of store/load data.
- MEM_LATENCY, 1, cycles chip_enable is held before data_load is sampled; legal range 1..15.
- PRIORITY_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 1 (load/store) always wins.

Ports:
- clock  in  1  single system clock, all state on posedge.
- reset_neg  in  1  asynchronous, active-low reset.
- req  in  2  per-port access request; bit 0 = fetch, bit 1 = load/store.
- req_we  in  2  per-port write flag (1 = store).
- req_addr  in  2 x ADDR_WIDTH  per-port address.
- req_wdata  in  2 x DATA_WIDTH  per-port store data.
- gnt  out  2  one-hot grant; request fields are captured in the cycle gnt is high.
- rvalid  out  2  one-hot, one-cycle completion pulse.
- rdata  out  DATA_WIDTH  load data, valid while rvalid is high.
- mem_address  out  ADDR_WIDTH  to memory.address.
- mem_data_store  out  DATA_WIDTH  to memory.data_store.
- mem_data_load  in  DATA_WIDTH  from memory.data_load.
- mem_write_enable  out  1  to memory.write_enable.
- mem_chip_enable  out  1  to memory.chip_enable.

Behaviour:
- Reset, asynchronous on reset_neg low:
  - state=IDLE; gnt, rvalid, rdata, mem_address, mem_data_store, mem_write_enable and mem_chip_enable all 0.
  - latency counter = 0; last_grant = 1, so port 0 wins the first round-robin tie.
- Reset asserted mid-access aborts the access: chip_enable drops immediately and no rvalid is issued.
- IDLE:
  - gnt is combinational from req.
  - If exactly one req bit is set, grant that port.
  - If both are set: PRIORITY_MODE=0 grants the port not equal to last_grant; PRIORITY_MODE=1 grants port 1.
  - On the posedge with gnt high: latch addr, we and wdata of the winner into mem_* registers; set mem_chip_enable=1; load counter=MEM_LATENCY-1; set last_grant to the winner; go to ACCESS.
- ACCESS:
  - gnt=0; chip_enable stays high.
  - While the counter is nonzero, decrement it.
  - When the counter is 0: on the posedge, capture mem_data_load into rdata (writes capture 0), drop chip_enable and write_enable, go to RESPOND.
- RESPOND:
  - rvalid[winner]=1 for exactly one cycle; rdata is held stable; go to IDLE.
  - No grant is issued in RESPOND.
- Timing:
  - gnt at cycle T; chip_enable high in cycles T+1..T+MEM_LATENCY; rvalid at T+MEM_LATENCY+1.
  - Next possible gnt is at T+MEM_LATENCY+2, so throughput is one access per MEM_LATENCY+2 cycles.
- Requester rules:
  - A requester holds req and its fields stable until it sees gnt; it may change them in the following cycle.
  - A req deasserted before gnt is simply not served.
  - A req held continuously after completion is re-arbitrated in IDLE like any new request.
- Round-robin fairness: with both ports requesting continuously, grants alternate 0,1,0,1… No port waits more than one access.
- Addresses pass through unmodified; no alignment check, no wrap handling. Address overflow is the requester's concern.
- The counter is 4 bits wide; MEM_LATENCY outside 1..15 is a fatal elaboration error.

Decomposition:
- Package therm_n1_mem_pkg holds:
  - constants PORT_FETCH=0 and PORT_LSU=1;
  - enum mem_arb_state_t {IDLE, ACCESS, RESPOND};
  - struct mem_req_t {we, addr, wdata}.
- Sub-module therm_n1_rr_picker: a two-way combinational picker taking req, last_grant and PRIORITY_MODE and producing a one-hot grant. It is reused later for register-file write-port sharing.

Test Plan:
- Reset: drive reset_neg=0 during ACCESS (MEM_LATENCY=3) -> chip_enable and every other output read 0 within the same cycle; no rvalid after release.
- Single load: port 0 req, addr=0x40; memory returns 0xDEADBEEF_CAFEF00D; MEM_LATENCY=1 -> gnt[0] at T, chip_enable at T+1 only, rvalid[0] at T+2 with rdata=0xDEADBEEF_CAFEF00D.
- Store: port 1 req_we=1, addr=0x80, wdata=0x1234 -> mem_write_enable=1 and mem_data_store=0x1234 during ACCESS; rvalid[1] with rdata=0.
- Round-robin contention: both req held for 4 accesses, PRIORITY_MODE=0 -> grant order 0,1,0,1; gnt spacing 3 cycles at MEM_LATENCY=1.
- Fixed priority: PRIORITY_MODE=1, both req held for 3 accesses -> all three grants go to port 1; port 0 is granted only after port 1 drops req.
- Latency sweep: MEM_LATENCY=4, single load -> chip_enable high exactly 4 cycles; rvalid at T+5; rdata equals data_load sampled at the T+4 posedge.

Source files
------------

// File: rtl/therm_n1_mem_pkg.sv
// Shared types and constants for the therm_n1 memory arbiter and its port picker.
package therm_n1_mem_pkg;

    localparam int PORT_FETCH = 0;
    localparam int PORT_LSU   = 1;

    // Widest request fields the arbiter accepts; narrower instances cast down.
    localparam int MEM_ADDR_MAX = 64;
    localparam int MEM_DATA_MAX = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } mem_arb_state_t;

    typedef struct packed {
        logic                    we;
        logic [MEM_ADDR_MAX-1:0] addr;
        logic [MEM_DATA_MAX-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/therm_n1_rr_picker.sv
// Two-way combinational grant picker: round-robin on last_grant, or fixed priority to port 1.
module therm_n1_rr_picker
    import therm_n1_mem_pkg::*;
#(
    parameter int PRIORITY_MODE = 0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        gnt = '0;
        case (req)
            2'b01: gnt[PORT_FETCH] = 1'b1;
            2'b10: gnt[PORT_LSU]   = 1'b1;
            2'b11: begin
                if (PRIORITY_MODE == 1 || last_grant == 1'b0) gnt[PORT_LSU]   = 1'b1;
                else                                          gnt[PORT_FETCH] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/therm_n1_memory_arbiter.sv
// Sequences the single-ported memory between fetch (port 0) and load/store (port 1) with a fixed latency.
module therm_n1_memory_arbiter
    import therm_n1_mem_pkg::*;
#(
    parameter int ADDR_WIDTH    = 64,
    parameter int DATA_WIDTH    = 64,
    parameter int MEM_LATENCY   = 1,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                       clock,
    input  logic                       reset_neg,
    input  logic [1:0]                 req,
    input  logic [1:0]                 req_we,
    input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]                 gnt,
    output logic [1:0]                 rvalid,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic [ADDR_WIDTH-1:0]      mem_address,
    output logic [DATA_WIDTH-1:0]      mem_data_store,
    input  logic [DATA_WIDTH-1:0]      mem_data_load,
    output logic                       mem_write_enable,
    output logic                       mem_chip_enable
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $fatal(1, "therm_n1_memory_arbiter: MEM_LATENCY must be in 1..15");
    end
    if (ADDR_WIDTH > MEM_ADDR_MAX || DATA_WIDTH > MEM_DATA_MAX) begin : g_bad_width
        $fatal(1, "therm_n1_memory_arbiter: field width exceeds package maximum");
    end

    mem_arb_state_t state_q, state_d;
    logic [3:0]     lat_cnt;
    logic           last_grant;
    logic [1:0]     pick;
    logic           win_idx;
    mem_req_t       sel_req;

    therm_n1_rr_picker #(
        .PRIORITY_MODE(PRIORITY_MODE)
    ) u_picker (
        .req       (req),
        .last_grant(last_grant),
        .gnt       (pick)
    );

    assign win_idx = pick[PORT_LSU];

    always_comb begin
        sel_req.we    = req_we[win_idx];
        sel_req.addr  = MEM_ADDR_MAX'(req_addr[win_idx]);
        sel_req.wdata = MEM_DATA_MAX'(req_wdata[win_idx]);
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clock or negedge reset_neg) begin
        if (!reset_neg) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        gnt     = '0;
        rvalid  = '0;
        case (state_q)
            IDLE: begin
                gnt = pick;
                if (|pick) state_d = ACCESS;
            end
            ACCESS: begin
                if (lat_cnt == 4'd0) state_d = RESPOND;
            end
            RESPOND: begin
                rvalid[last_grant] = 1'b1;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // last_grant resets to port 1 so port 0 wins the first round-robin tie.
    always_ff @(posedge clock or negedge reset_neg) begin
        if (!reset_neg) begin
            lat_cnt          <= 4'd0;
            last_grant       <= 1'b1;
            rdata            <= '0;
            mem_address      <= '0;
            mem_data_store   <= '0;
            mem_write_enable <= 1'b0;
            mem_chip_enable  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|gnt) begin
                        mem_address      <= ADDR_WIDTH'(sel_req.addr);
                        mem_data_store   <= DATA_WIDTH'(sel_req.wdata);
                        mem_write_enable <= sel_req.we;
                        mem_chip_enable  <= 1'b1;
                        lat_cnt          <= 4'(MEM_LATENCY - 1);
                        last_grant       <= win_idx;
                    end
                end
                ACCESS: begin
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else begin
                        // Stores complete with zero data so rdata never leaks stale memory contents.
                        rdata            <= mem_write_enable ? '0 : mem_data_load;
                        mem_chip_enable  <= 1'b0;
                        mem_write_enable <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_therm_n1_memory_arbiter.sv
// Scoreboard bench for therm_n1_memory_arbiter across latency and priority-mode variants.
module tb_therm_n1_memory_arbiter;

    localparam logic [63:0] XMASK = 64'hA5A5_0000_5A5A_0000;
    localparam logic [63:0] LOAD0 = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] SWEEP = 64'h0123_4567_0000_1000;

    typedef struct {
        int          port;
        logic [63:0] data;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset_neg;
    logic [1:0]       req, req_we;
    logic [1:0][63:0] req_addr, req_wdata;
    logic [63:0]      mem_data_load, mem_fixed;
    logic             mem_use_addr;
    int               mem_sel;

    logic [1:0]  gnt_o    [4];
    logic [1:0]  rvalid_o [4];
    logic [63:0] rdata_o  [4];
    logic [63:0] addr_o   [4];
    logic [63:0] ds_o     [4];
    logic        we_o     [4];
    logic        ce_o     [4];

    exp_t sb[$];
    int   exp_ports[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    assign mem_data_load = mem_use_addr ? (addr_o[mem_sel] ^ XMASK) : mem_fixed;

    // Instances: 0 = RR/L1, 1 = RR/L3, 2 = fixed/L1, 3 = RR/L4
    therm_n1_memory_arbiter #(.MEM_LATENCY(1), .PRIORITY_MODE(0)) dut0 (
        .clock(clock), .reset_neg(reset_neg), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt_o[0]), .rvalid(rvalid_o[0]),
        .rdata(rdata_o[0]), .mem_address(addr_o[0]), .mem_data_store(ds_o[0]),
        .mem_data_load(mem_data_load), .mem_write_enable(we_o[0]), .mem_chip_enable(ce_o[0]));
    therm_n1_memory_arbiter #(.MEM_LATENCY(3), .PRIORITY_MODE(0)) dut1 (
        .clock(clock), .reset_neg(reset_neg), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt_o[1]), .rvalid(rvalid_o[1]),
        .rdata(rdata_o[1]), .mem_address(addr_o[1]), .mem_data_store(ds_o[1]),
        .mem_data_load(mem_data_load), .mem_write_enable(we_o[1]), .mem_chip_enable(ce_o[1]));
    therm_n1_memory_arbiter #(.MEM_LATENCY(1), .PRIORITY_MODE(1)) dut2 (
        .clock(clock), .reset_neg(reset_neg), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt_o[2]), .rvalid(rvalid_o[2]),
        .rdata(rdata_o[2]), .mem_address(addr_o[2]), .mem_data_store(ds_o[2]),
        .mem_data_load(mem_data_load), .mem_write_enable(we_o[2]), .mem_chip_enable(ce_o[2]));
    therm_n1_memory_arbiter #(.MEM_LATENCY(4), .PRIORITY_MODE(0)) dut3 (
        .clock(clock), .reset_neg(reset_neg), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt_o[3]), .rvalid(rvalid_o[3]),
        .rdata(rdata_o[3]), .mem_address(addr_o[3]), .mem_data_store(ds_o[3]),
        .mem_data_load(mem_data_load), .mem_write_enable(we_o[3]), .mem_chip_enable(ce_o[3]));

    function automatic logic [1:0] onehot(input int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic do_reset();
        reset_neg    = 1'b0;
        req          = '0;
        req_we       = '0;
        req_addr     = '0;
        req_wdata    = '0;
        mem_use_addr = 1'b0;
        mem_fixed    = '0;
        mem_sel      = 0;
        sb.delete();
        exp_ports.delete();
        @(negedge clock);
        @(negedge clock);
        reset_neg = 1'b1;
    endtask

    task automatic test_reset();
        logic seen;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({gnt_o[i], rvalid_o[i], rdata_o[i], addr_o[i], ds_o[i], we_o[i], ce_o[i]} !== '0) begin
                failures++;
                $display("FAIL reset_state dut%0d: gnt=%b rvalid=%b rdata=%h addr=%h ds=%h we=%b ce=%b, expected all zero",
                         i, gnt_o[i], rvalid_o[i], rdata_o[i], addr_o[i], ds_o[i], we_o[i], ce_o[i]);
            end
        end
        // Start an access on the latency-3 instance, then abort it mid-ACCESS.
        req         = 2'b01;
        req_addr[0] = 64'h10;
        #1;
        checks++;
        if (gnt_o[1] !== 2'b01) begin
            failures++;
            $display("FAIL abort_gnt: gnt=%b expected 01", gnt_o[1]);
        end
        @(negedge clock);
        req = 2'b00;
        #1;
        checks++;
        if (ce_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL abort_ce_before: ce=%b expected 1", ce_o[1]);
        end
        #1;
        reset_neg = 1'b0;
        #1;
        checks++;
        if ({gnt_o[1], rvalid_o[1], rdata_o[1], addr_o[1], ds_o[1], we_o[1], ce_o[1]} !== '0) begin
            failures++;
            $display("FAIL abort_outputs: ce=%b addr=%h gnt=%b rvalid=%b, expected all zero",
                     ce_o[1], addr_o[1], gnt_o[1], rvalid_o[1]);
        end
        @(negedge clock);
        reset_neg = 1'b1;
        seen      = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (rvalid_o[1] !== 2'b00 || ce_o[1] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_rvalid: activity seen after aborted access, expected none");
        end
    endtask

    task automatic test_single_load();
        do_reset();
        mem_fixed   = LOAD0;
        req         = 2'b01;
        req_we      = 2'b00;
        req_addr[0] = 64'h40;
        sb.push_back('{port: 0, data: LOAD0});
        #1;
        checks++;
        if (gnt_o[0] !== 2'b01) begin
            failures++;
            $display("FAIL load_gnt: gnt=%b expected 01", gnt_o[0]);
        end
        @(negedge clock);
        req = 2'b00;
        #1;
        checks++;
        if (ce_o[0] !== 1'b1 || addr_o[0] !== 64'h40 || we_o[0] !== 1'b0 || gnt_o[0] !== 2'b00) begin
            failures++;
            $display("FAIL load_access: ce=%b addr=%h we=%b gnt=%b expected ce=1 addr=40 we=0 gnt=00",
                     ce_o[0], addr_o[0], we_o[0], gnt_o[0]);
        end
        @(negedge clock);
        #1;
        e = sb.pop_front();
        checks++;
        if (rvalid_o[0] !== onehot(e.port) || rdata_o[0] !== e.data || ce_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL load_rsp: rvalid=%b rdata=%h ce=%b expected rvalid=%b rdata=%h ce=0",
                     rvalid_o[0], rdata_o[0], ce_o[0], onehot(e.port), e.data);
        end
        @(negedge clock);
        #1;
        checks++;
        if (rvalid_o[0] !== 2'b00 || rdata_o[0] !== LOAD0) begin
            failures++;
            $display("FAIL load_after: rvalid=%b rdata=%h expected rvalid=00 rdata=%h", rvalid_o[0], rdata_o[0], LOAD0);
        end
    endtask

    task automatic test_store();
        do_reset();
        mem_fixed    = 64'hFFFF_FFFF_FFFF_FFFF;
        req          = 2'b10;
        req_we       = 2'b10;
        req_addr[1]  = 64'h80;
        req_wdata[1] = 64'h1234;
        sb.push_back('{port: 1, data: 64'h0});
        #1;
        checks++;
        if (gnt_o[0] !== 2'b10) begin
            failures++;
            $display("FAIL store_gnt: gnt=%b expected 10", gnt_o[0]);
        end
        @(negedge clock);
        req    = 2'b00;
        req_we = 2'b00;
        #1;
        checks++;
        if (we_o[0] !== 1'b1 || ds_o[0] !== 64'h1234 || addr_o[0] !== 64'h80 || ce_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL store_access: we=%b ds=%h addr=%h ce=%b expected we=1 ds=1234 addr=80 ce=1",
                     we_o[0], ds_o[0], addr_o[0], ce_o[0]);
        end
        @(negedge clock);
        #1;
        e = sb.pop_front();
        checks++;
        if (rvalid_o[0] !== onehot(e.port) || rdata_o[0] !== e.data || we_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL store_rsp: rvalid=%b rdata=%h we=%b expected rvalid=%b rdata=%h we=0",
                     rvalid_o[0], rdata_o[0], we_o[0], onehot(e.port), e.data);
        end
    endtask

    // Holds both requests and checks grant order, spacing and responses against the scoreboard.
    task automatic run_contention(input int idx, input int drop1_after, input int total,
                                  input int spacing, input string name);
        int ngnt   = 0;
        int nrsp   = 0;
        int last_t = -1;
        for (int c = 0; c < 40 && nrsp < total; c++) begin
            if (c > 0) @(negedge clock);
            if (ngnt == drop1_after) req[1] = 1'b0;
            if (ngnt == total) req = 2'b00;
            #1;
            if (gnt_o[idx] !== 2'b00) begin
                checks++;
                if (ngnt >= total || gnt_o[idx] !== onehot(exp_ports[ngnt])) begin
                    failures++;
                    $display("FAIL %s_gnt%0d: gnt=%b expected %b", name, ngnt, gnt_o[idx],
                             (ngnt < total) ? onehot(exp_ports[ngnt]) : 2'b00);
                end
                if (spacing > 0 && last_t >= 0) begin
                    checks++;
                    if (c - last_t != spacing) begin
                        failures++;
                        $display("FAIL %s_spacing%0d: got %0d cycles expected %0d", name, ngnt, c - last_t, spacing);
                    end
                end
                last_t = c;
                ngnt++;
            end
            if (rvalid_o[idx] !== 2'b00) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL %s_extra_rsp: rvalid=%b expected none", name, rvalid_o[idx]);
                end else begin
                    e = sb.pop_front();
                    if (rvalid_o[idx] !== onehot(e.port) || rdata_o[idx] !== e.data) begin
                        failures++;
                        $display("FAIL %s_rsp%0d: rvalid=%b rdata=%h expected rvalid=%b rdata=%h",
                                 name, nrsp, rvalid_o[idx], rdata_o[idx], onehot(e.port), e.data);
                    end
                end
                nrsp++;
            end
        end
        checks++;
        if (ngnt != total || nrsp != total) begin
            failures++;
            $display("FAIL %s_count: grants=%0d responses=%0d expected %0d each", name, ngnt, nrsp, total);
        end
    endtask

    task automatic test_round_robin();
        int last = 1;
        int p;
        do_reset();
        mem_use_addr = 1'b1;
        mem_sel      = 0;
        req_addr[0]  = 64'h100;
        req_addr[1]  = 64'h200;
        for (int k = 0; k < 4; k++) begin
            p    = 1 - last;
            last = p;
            exp_ports.push_back(p);
            sb.push_back('{port: p, data: req_addr[p] ^ XMASK});
        end
        req = 2'b11;
        run_contention(0, 99, 4, 3, "rr");
    endtask

    task automatic test_fixed_priority();
        do_reset();
        mem_use_addr = 1'b1;
        mem_sel      = 2;
        req_addr[0]  = 64'h400;
        req_addr[1]  = 64'h300;
        for (int k = 0; k < 4; k++) begin
            exp_ports.push_back(k < 3 ? 1 : 0);
            sb.push_back('{port: (k < 3 ? 1 : 0), data: req_addr[k < 3 ? 1 : 0] ^ XMASK});
        end
        req = 2'b11;
        run_contention(2, 3, 4, 3, "prio");
    endtask

    task automatic test_latency_sweep();
        int ce_cnt   = 0;
        int ce_first = -1;
        int rv_k     = -1;
        do_reset();
        req         = 2'b01;
        req_addr[0] = 64'h55;
        sb.push_back('{port: 0, data: SWEEP + 64'd4});
        #1;
        checks++;
        if (gnt_o[3] !== 2'b01) begin
            failures++;
            $display("FAIL sweep_gnt: gnt=%b expected 01", gnt_o[3]);
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 1) req = 2'b00;
            mem_fixed = SWEEP + 64'(k);
            #1;
            if (ce_o[3] === 1'b1) begin
                ce_cnt++;
                if (ce_first < 0) ce_first = k;
            end
            if (rvalid_o[3] !== 2'b00) begin
                rv_k = k;
                e    = sb.pop_front();
                checks++;
                if (rvalid_o[3] !== onehot(e.port) || rdata_o[3] !== e.data) begin
                    failures++;
                    $display("FAIL sweep_rsp: rvalid=%b rdata=%h expected rvalid=%b rdata=%h",
                             rvalid_o[3], rdata_o[3], onehot(e.port), e.data);
                end
            end
        end
        checks++;
        if (ce_cnt != 4 || ce_first != 1 || rv_k != 5) begin
            failures++;
            $display("FAIL sweep_timing: ce_cycles=%0d ce_first=T+%0d rvalid=T+%0d expected 4, T+1, T+5",
                     ce_cnt, ce_first, rv_k);
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_store();
        test_round_robin();
        test_fixed_priority();
        test_latency_sweep();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d responses never arrived, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
